// File: rtl/load_issue_queue_if.sv
// Load issue queue bus bundle: dispatch request/payload, CDB broadcast,
// flush and store-fence inputs, issue port and occupancy.
// master = the core side driving dispatch/cdb; slave = the queue itself.
interface load_issue_queue_if;
  logic         flush;
  logic         disp_valid;
  logic         disp_ready;
  logic [2:0]   disp_width;
  logic [5:0]   disp_dest;
  logic         disp_base_valid;
  logic [5:0]   disp_base_tag;
  logic [31:0]  disp_base;
  logic [31:0]  disp_opr2;
  logic [31:0]  disp_offset;
  logic [37:0]  cdb;
  logic         issue_en;
  logic [104:0] issue_op;
  logic         store_pending;
  logic [2:0]   occupancy;

  modport master (
    output flush, disp_valid, disp_width, disp_dest, disp_base_valid,
           disp_base_tag, disp_base, disp_opr2, disp_offset, cdb, store_pending,
    input  disp_ready, issue_en, issue_op, occupancy
  );

  modport slave (
    input  flush, disp_valid, disp_width, disp_dest, disp_base_valid,
           disp_base_tag, disp_base, disp_opr2, disp_offset, cdb, store_pending,
    output disp_ready, issue_en, issue_op, occupancy
  );
endinterface

// File: rtl/load_issue_queue.sv
// load_issue_queue: 4-entry age-ordered collapsing queue of loads waiting on
// their base operand. Entry 0 is the oldest; the oldest ready entry issues,
// younger entries slide down, and new loads land in the first free slot.
// Optional feature: define LOADQ_STORE_FENCE_EN to hold issue while a store
// commit is pending (queue contents and wakeups keep updating).
module load_issue_queue (
  input logic              clk,
  input logic              reset,
  load_issue_queue_if.slave bus
);

  localparam int DEPTH = 4;

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [5:0]  base_tag;
    logic [2:0]  width;
    logic [5:0]  dest;
    logic [31:0] base;
    logic [31:0] opr2;
    logic [31:0] offset;
  } entry_t;

  entry_t      q      [DEPTH];
  entry_t      q_next [DEPTH];
  entry_t      woke   [DEPTH];
  entry_t      new_entry;

  logic [2:0]  count;
  logic        found;
  logic [1:0]  sel;
  logic        fence;
  logic        fire;
  logic        accept;
  logic [2:0]  slot;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        cdb_hit_new;

  assign cdb_tag  = bus.cdb[37:32];
  assign cdb_data = bus.cdb[31:0];

`ifdef LOADQ_STORE_FENCE_EN
  assign fence = bus.store_pending;
`else
  logic unused_store_pending;
  assign unused_store_pending = bus.store_pending;
  assign fence = 1'b0;
`endif

  // Count valid entries; the queue collapses, so valid bits are contiguous.
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + 3'(q[i].valid);
    end
  end

  // Pick the oldest entry whose base operand is available.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && q[i].valid && q[i].ready) begin
        found = 1'b1;
        sel   = 2'(i);
      end
    end
  end

  assign fire           = found && !bus.flush && !fence;
  assign bus.issue_en   = fire;
  assign bus.issue_op   = fire ? {q[sel].width, q[sel].dest, q[sel].base,
                                  q[sel].opr2, q[sel].offset} : '0;
  assign bus.disp_ready = (count < 3'd4);
  assign bus.occupancy  = count;
  assign accept         = bus.disp_valid && bus.disp_ready && !bus.flush;
  assign slot           = count - {2'b00, fire};
  assign cdb_hit_new    = (cdb_tag != 6'd0) && (cdb_tag == bus.disp_base_tag);

  // Build the incoming entry, capturing a same-cycle CDB broadcast if it
  // produces the missing base operand.
  always_comb begin
    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.ready    = bus.disp_base_valid;
    new_entry.base_tag = bus.disp_base_tag;
    new_entry.width    = bus.disp_width;
    new_entry.dest     = bus.disp_dest;
    new_entry.base     = bus.disp_base;
    new_entry.opr2     = bus.disp_opr2;
    new_entry.offset   = bus.disp_offset;
    if (!bus.disp_base_valid && cdb_hit_new) begin
      new_entry.ready = 1'b1;
      new_entry.base  = cdb_data;
    end
  end

  // Next queue state: wake waiting entries, remove the issued one by shifting
  // younger entries down, append the dispatch, then apply flush.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = q[i];
      if (q[i].valid && !q[i].ready && (cdb_tag != 6'd0) &&
          (cdb_tag == q[i].base_tag)) begin
        woke[i].ready = 1'b1;
        woke[i].base  = cdb_data;
      end
    end

    for (int i = 0; i < DEPTH - 1; i++) begin
      q_next[i] = (fire && (2'(i) >= sel)) ? woke[i + 1] : woke[i];
    end
    q_next[DEPTH - 1] = fire ? '0 : woke[DEPTH - 1];

    for (int i = 0; i < DEPTH; i++) begin
      if (accept && (slot == 3'(i))) begin
        q_next[i] = new_entry;
      end
    end

    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_next[i].valid = 1'b0;
        q_next[i].ready = 1'b0;
      end
    end
  end

  // Queue state register with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= q_next[i];
      end
    end
  end

endmodule
